spec_tlb_unit: RTL and testbench



---
 rtl/spec_tlb_if.sv | 34 +++
 rtl/spec_tlb_unit.sv | 193 +++++++++++++++++++
 tb/tb_spec_tlb_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spec_tlb_if.sv
// Request/response and page-table handshake bundle for the speculative TLB.
interface spec_tlb_if;
    logic        TRANS_RQST;
    logic        SPEC_TLB_RQST;
    logic [8:0]  VIRT_ADDR_LOOKUP;
    logic        SPEC_HIT;
    logic        TLB_HIT;
    logic [8:0]  PHY_ADDR_TRANS;
    logic        DONE_TRANS;
    logic        PAGE_8B_RQST;
    logic [5:0]  PAGE_8B_LOOKUP;
    logic [11:0] PAGE_8B_RECV;
    logic        PAGE_8B_COMPLETE;
    logic        PAGE_32B_RQST;
    logic [3:0]  PAGE_32B_LOOKUP;
    logic [7:0]  PAGE_32B_RECV;
    logic        PAGE_32B_COMPLETE;

    // Requester and page-table side.
    modport master (
        output TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP,
        output PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
        input  SPEC_HIT, TLB_HIT, PHY_ADDR_TRANS, DONE_TRANS,
        input  PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP
    );

    // TLB side.
    modport slave (
        input  TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP,
        input  PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
        output SPEC_HIT, TLB_HIT, PHY_ADDR_TRANS, DONE_TRANS,
        output PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP
    );
endinterface

// File: rtl/spec_tlb_unit.sv
// Fully-associative TLB for 8B/32B pages with two-level page walk on miss
// and neighbour-based speculative translation.
module spec_tlb_unit #(
    parameter int unsigned NUM_ENTRIES = 4
) (
    input logic       clk,
    input logic       rst_n,
    spec_tlb_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef struct packed {
        logic       valid;
        logic       size;
        logic [5:0] vpn;
        logic [5:0] ppn;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WALK32,
        S_WAIT32,
        S_WALK8,
        S_WAIT8,
        S_RESP
    } state_t;

    state_t           state;
    tlb_entry_t       entries [NUM_ENTRIES];
    logic [IDX_W-1:0] ptr;
    logic [8:0]       va;
    logic             spec_en;
    logic             spec_made;
    logic [8:0]       spec_pa;
    logic [8:0]       res_pa;
    logic             res_hit;
    logic             res_valid;

    logic             hit;
    logic [8:0]       hit_pa;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] fill_idx;
    logic             cand_found;
    logic [5:0]       cand_ppn;
    logic [8:0]       cand_pa;
    logic             unused_bits;

    assign unused_bits = ^{bus.PAGE_8B_RECV[10:6], bus.PAGE_32B_RECV[6:4]};

    // Associative match (lowest index wins), first free slot and speculation source.
    always_comb begin
        hit        = 1'b0;
        hit_pa     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        cand_found = 1'b0;
        cand_ppn   = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (entries[i].valid && !hit) begin
                if (!entries[i].size && (entries[i].vpn == va[8:3])) begin
                    hit    = 1'b1;
                    hit_pa = {entries[i].ppn, va[2:0]};
                end else if (entries[i].size && (entries[i].vpn[5:2] == va[8:5])) begin
                    hit    = 1'b1;
                    hit_pa = {entries[i].ppn[3:0], va[4:0]};
                end
            end
            if (!entries[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (entries[i].valid && !entries[i].size && !cand_found &&
                (entries[i].vpn[5:2] == va[8:5])) begin
                cand_found = 1'b1;
                cand_ppn   = entries[i].ppn + (va[8:3] - entries[i].vpn);
            end
        end
        cand_pa  = {cand_ppn, va[2:0]};
        fill_idx = free_found ? free_idx : ptr;
    end

    // Control FSM with registered outputs; one-cycle strobes default low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            ptr                 <= '0;
            va                  <= '0;
            spec_en             <= 1'b0;
            spec_made           <= 1'b0;
            spec_pa             <= '0;
            res_pa              <= '0;
            res_hit             <= 1'b0;
            res_valid           <= 1'b0;
            bus.SPEC_HIT        <= 1'b0;
            bus.TLB_HIT         <= 1'b0;
            bus.PHY_ADDR_TRANS  <= '0;
            bus.DONE_TRANS      <= 1'b0;
            bus.PAGE_8B_RQST    <= 1'b0;
            bus.PAGE_8B_LOOKUP  <= '0;
            bus.PAGE_32B_RQST   <= 1'b0;
            bus.PAGE_32B_LOOKUP <= '0;
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                entries[i] <= '0;
            end
        end else begin
            bus.DONE_TRANS    <= 1'b0;
            bus.PAGE_8B_RQST  <= 1'b0;
            bus.PAGE_32B_RQST <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.TRANS_RQST) begin
                        va           <= bus.VIRT_ADDR_LOOKUP;
                        spec_en      <= bus.SPEC_TLB_RQST;
                        spec_made    <= 1'b0;
                        bus.SPEC_HIT <= 1'b0;
                        bus.TLB_HIT  <= 1'b0;
                        state        <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        res_pa    <= hit_pa;
                        res_hit   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        res_hit   <= 1'b0;
                        spec_made <= spec_en && cand_found;
                        spec_pa   <= cand_pa;
                        state     <= S_WALK32;
                    end
                end
                S_WALK32: begin
                    bus.PAGE_32B_RQST   <= 1'b1;
                    bus.PAGE_32B_LOOKUP <= va[8:5];
                    state               <= S_WAIT32;
                end
                S_WAIT32: begin
                    if (bus.PAGE_32B_COMPLETE) begin
                        if (bus.PAGE_32B_RECV[7]) begin
                            res_pa            <= {bus.PAGE_32B_RECV[3:0], va[4:0]};
                            res_valid         <= 1'b1;
                            entries[fill_idx] <= '{valid: 1'b1, size: 1'b1,
                                                   vpn: {va[8:5], 2'b00},
                                                   ppn: {2'b00, bus.PAGE_32B_RECV[3:0]}};
                            if (!free_found) begin
                                ptr <= (ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : ptr + 1'b1;
                            end
                            state <= S_RESP;
                        end else begin
                            state <= S_WALK8;
                        end
                    end
                end
                S_WALK8: begin
                    bus.PAGE_8B_RQST   <= 1'b1;
                    bus.PAGE_8B_LOOKUP <= va[8:3];
                    state              <= S_WAIT8;
                end
                S_WAIT8: begin
                    if (bus.PAGE_8B_COMPLETE) begin
                        if (bus.PAGE_8B_RECV[11]) begin
                            res_pa            <= {bus.PAGE_8B_RECV[5:0], va[2:0]};
                            res_valid         <= 1'b1;
                            entries[fill_idx] <= '{valid: 1'b1, size: 1'b0,
                                                   vpn: va[8:3],
                                                   ppn: bus.PAGE_8B_RECV[5:0]};
                            if (!free_found) begin
                                ptr <= (ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : ptr + 1'b1;
                            end
                        end else begin
                            res_pa    <= '0;
                            res_valid <= 1'b0;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    bus.DONE_TRANS     <= 1'b1;
                    bus.PHY_ADDR_TRANS <= res_pa;
                    bus.TLB_HIT        <= res_hit;
                    bus.SPEC_HIT       <= !res_hit && spec_made && res_valid && (spec_pa == res_pa);
                    state              <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spec_tlb_unit.sv
// Directed self-checking bench for spec_tlb_unit with a page-table responder
// folded into the transaction task.
module tb_spec_tlb_unit;

    logic clk;
    logic rst_n;
    spec_tlb_if bus ();

    spec_tlb_unit #(.NUM_ENTRIES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] pt8  [64];
    logic [7:0]  pt32 [16];

    int n_vec;
    int n_bad;

    logic [8:0] r_pa;
    logic       r_tlb;
    logic       r_spec;
    logic       r_done;
    int         r_lat;
    int         r_n32;
    int         r_n8;
    logic [3:0] r_lk32;
    logic [5:0] r_lk8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and serve page-table walks; stop8 leaves the 8B walk hanging.
    task automatic do_trans(input logic [8:0] va, input logic spec, input bit stop8);
        bit pend32;
        bit pend8;
        pend32 = 1'b0;
        pend8  = 1'b0;
        r_done = 1'b0;
        r_n32  = 0;
        r_n8   = 0;
        r_lat  = 0;
        @(negedge clk);
        bus.TRANS_RQST       = 1'b1;
        bus.VIRT_ADDR_LOOKUP = va;
        bus.SPEC_TLB_RQST    = spec;
        @(negedge clk);
        bus.TRANS_RQST    = 1'b0;
        bus.SPEC_TLB_RQST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.PAGE_32B_COMPLETE = 1'b0;
            bus.PAGE_8B_COMPLETE  = 1'b0;
            if (pend32) begin
                bus.PAGE_32B_RECV     = pt32[r_lk32];
                bus.PAGE_32B_COMPLETE = 1'b1;
                pend32 = 1'b0;
            end
            if (pend8) begin
                bus.PAGE_8B_RECV     = pt8[r_lk8];
                bus.PAGE_8B_COMPLETE = 1'b1;
                pend8 = 1'b0;
            end
            if (bus.PAGE_32B_RQST) begin
                r_n32++;
                r_lk32 = bus.PAGE_32B_LOOKUP;
                pend32 = 1'b1;
            end
            if (bus.PAGE_8B_RQST) begin
                r_n8++;
                r_lk8 = bus.PAGE_8B_LOOKUP;
                if (stop8) return;
                pend8 = 1'b1;
            end
            if (bus.DONE_TRANS) begin
                r_done = 1'b1;
                r_pa   = bus.PHY_ADDR_TRANS;
                r_tlb  = bus.TLB_HIT;
                r_spec = bus.SPEC_HIT;
                break;
            end
            @(negedge clk);
            r_lat++;
        end
        bus.PAGE_32B_COMPLETE = 1'b0;
        bus.PAGE_8B_COMPLETE  = 1'b0;
        if (!r_done) chk("timeout", 32'(r_done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   dones;
        logic [8:0] rep_va  [5];
        logic [8:0] rep_pa  [5];

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.TRANS_RQST        = 1'b0;
        bus.SPEC_TLB_RQST     = 1'b0;
        bus.VIRT_ADDR_LOOKUP  = '0;
        bus.PAGE_8B_RECV      = '0;
        bus.PAGE_8B_COMPLETE  = 1'b0;
        bus.PAGE_32B_RECV     = '0;
        bus.PAGE_32B_COMPLETE = 1'b0;
        for (int i = 0; i < 64; i++) pt8[i] = 12'h000;
        for (int i = 0; i < 16; i++) pt32[i] = 8'h00;
        pt32[3]    = 8'h8A;
        pt8[6'h02] = 12'h810;
        pt8[6'h03] = 12'h811;

        repeat (2) @(negedge clk);
        chk("rst_done",   32'(bus.DONE_TRANS),     32'd0);
        chk("rst_pa",     32'(bus.PHY_ADDR_TRANS), 32'd0);
        chk("rst_tlbhit", 32'(bus.TLB_HIT),        32'd0);
        chk("rst_spec",   32'(bus.SPEC_HIT),       32'd0);
        chk("rst_rq32",   32'(bus.PAGE_32B_RQST),  32'd0);
        chk("rst_rq8",    32'(bus.PAGE_8B_RQST),   32'd0);
        rst_n = 1'b1;

        // Cold 32B walk then hit.
        do_trans(9'h07A, 1'b0, 1'b0);
        chk("c32_n32",  32'(r_n32),  32'd1);
        chk("c32_lk32", 32'(r_lk32), 32'd3);
        chk("c32_n8",   32'(r_n8),   32'd0);
        chk("c32_pa",   32'(r_pa),   32'h15A);
        chk("c32_tlb",  32'(r_tlb),  32'd0);
        chk("c32_spec", 32'(r_spec), 32'd0);
        chk("c32_lat",  32'(r_lat),  32'd5);
        @(negedge clk);
        chk("c32_done_1cyc", 32'(bus.DONE_TRANS),     32'd0);
        chk("c32_pa_held",   32'(bus.PHY_ADDR_TRANS), 32'h15A);

        do_trans(9'h07A, 1'b0, 1'b0);
        chk("h32_tlb", 32'(r_tlb), 32'd1);
        chk("h32_n32", 32'(r_n32), 32'd0);
        chk("h32_n8",  32'(r_n8),  32'd0);
        chk("h32_lat", 32'(r_lat), 32'd2);
        chk("h32_pa",  32'(r_pa),  32'h15A);

        // 8B fallback.
        do_trans(9'h015, 1'b0, 1'b0);
        chk("f8_n32", 32'(r_n32), 32'd1);
        chk("f8_n8",  32'(r_n8),  32'd1);
        chk("f8_lk8", 32'(r_lk8), 32'h02);
        chk("f8_pa",  32'(r_pa),  32'h085);
        chk("f8_tlb", 32'(r_tlb), 32'd0);

        // Correct speculation; walk still happens.
        do_trans(9'h01D, 1'b1, 1'b0);
        chk("spok_n8",   32'(r_n8),   32'd1);
        chk("spok_pa",   32'(r_pa),   32'h08D);
        chk("spok_spec", 32'(r_spec), 32'd1);
        chk("spok_tlb",  32'(r_tlb),  32'd0);

        // Speculation request that hits the TLB never reports SPEC_HIT.
        do_trans(9'h01D, 1'b1, 1'b0);
        chk("sphit_tlb",  32'(r_tlb),  32'd1);
        chk("sphit_spec", 32'(r_spec), 32'd0);

        // Fault, then repeat walks again.
        do_trans(9'h1FF, 1'b0, 1'b0);
        chk("flt_pa",   32'(r_pa),   32'h000);
        chk("flt_tlb",  32'(r_tlb),  32'd0);
        chk("flt_spec", 32'(r_spec), 32'd0);
        do_trans(9'h1FF, 1'b0, 1'b0);
        chk("flt2_n32", 32'(r_n32), 32'd1);
        chk("flt2_n8",  32'(r_n8),  32'd1);
        chk("flt2_pa",  32'(r_pa),  32'h000);

        // Wrong speculation from a fresh TLB.
        pulse_reset();
        pt8[6'h03] = 12'h820;
        do_trans(9'h015, 1'b0, 1'b0);
        chk("spw_fill_pa", 32'(r_pa), 32'h085);
        do_trans(9'h01D, 1'b1, 1'b0);
        chk("spw_pa",   32'(r_pa),   32'h105);
        chk("spw_spec", 32'(r_spec), 32'd0);
        chk("spw_tlb",  32'(r_tlb),  32'd0);

        // Replacement: five 8B fills into four entries.
        pulse_reset();
        rep_va[0] = 9'h100; rep_pa[0] = 9'h008; pt8[6'h20] = 12'h801;
        rep_va[1] = 9'h108; rep_pa[1] = 9'h010; pt8[6'h21] = 12'h802;
        rep_va[2] = 9'h110; rep_pa[2] = 9'h018; pt8[6'h22] = 12'h803;
        rep_va[3] = 9'h118; rep_pa[3] = 9'h020; pt8[6'h23] = 12'h804;
        rep_va[4] = 9'h120; rep_pa[4] = 9'h028; pt8[6'h24] = 12'h805;
        for (int i = 0; i < 5; i++) begin
            do_trans(rep_va[i], 1'b0, 1'b0);
            chk($sformatf("rep_fill%0d_pa", i), 32'(r_pa), 32'(rep_pa[i]));
        end
        for (int i = 1; i < 5; i++) begin
            do_trans(rep_va[i], 1'b0, 1'b0);
            chk($sformatf("rep_hit%0d_tlb", i), 32'(r_tlb), 32'd1);
            chk($sformatf("rep_hit%0d_pa", i),  32'(r_pa),  32'(rep_pa[i]));
        end
        do_trans(rep_va[0], 1'b0, 1'b0);
        chk("rep_evict_tlb", 32'(r_tlb), 32'd0);
        chk("rep_evict_n8",  32'(r_n8),  32'd1);
        chk("rep_evict_pa",  32'(r_pa),  32'h008);

        // Reset in WAIT8, late COMPLETE ignored, TLB emptied.
        do_trans(9'h015, 1'b0, 1'b1);
        chk("mid_lk8", 32'(r_lk8), 32'h02);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_pa",     32'(bus.PHY_ADDR_TRANS), 32'd0);
        chk("mid_tlbhit", 32'(bus.TLB_HIT),        32'd0);
        chk("mid_lk8rst", 32'(bus.PAGE_8B_LOOKUP), 32'd0);
        chk("mid_done",   32'(bus.DONE_TRANS),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.PAGE_8B_RECV     = 12'h810;
        bus.PAGE_8B_COMPLETE = 1'b1;
        @(negedge clk);
        bus.PAGE_8B_COMPLETE = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.DONE_TRANS) dones++;
            @(negedge clk);
        end
        chk("mid_late_done", 32'(dones), 32'd0);
        do_trans(9'h120, 1'b0, 1'b0);
        chk("mid_empty_tlb", 32'(r_tlb), 32'd0);
        chk("mid_empty_n8",  32'(r_n8),  32'd1);
        chk("mid_empty_pa",  32'(r_pa),  32'h028);
        do_trans(9'h015, 1'b0, 1'b0);
        chk("mid_next_pa",  32'(r_pa),  32'h085);
        chk("mid_next_tlb", 32'(r_tlb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
